downsample_img: RTL and testbench



---
 rtl/sift_pkg.sv | 17 +
 rtl/box2x2_accum.sv | 62 ++++++
 rtl/downsample_img.sv | 160 ++++++++++++++++
 tb/tb_downsample_img.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sift_pkg.sv
// Shared definitions for the SIFT octave pipeline (blur and downsample stages).
package sift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ds_state_t;

  // Cycles from a read address being presented to its data on the BRAM output.
  localparam int unsigned BRAM_READ_LATENCY = 2;

  localparam int DS_MODE_AVG      = 0;
  localparam int DS_MODE_DECIMATE = 1;

endpackage

// File: rtl/box2x2_accum.sv
// Reduces the four pixels of a 2x2 block (phases 0..3) to one output pixel,
// either as a rounded average or by keeping the phase-0 pixel.
module box2x2_accum
  import sift_pkg::*;
#(
  parameter int BIT_DEPTH = 8,
  parameter int MODE      = DS_MODE_AVG
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [BIT_DEPTH-1:0] pixel_i,
  input  logic [1:0]           phase_i,
  input  logic                 valid_i,
  output logic [BIT_DEPTH-1:0] result_o,
  output logic                 result_valid_o
);

  localparam int AW = BIT_DEPTH + 2;

  logic [AW-1:0]        acc_q, acc_d;
  logic [BIT_DEPTH-1:0] result_q, result_d;
  logic                 result_valid_q, result_valid_d;

  // Load on phase 0, accumulate on later phases, emit the reduced pixel on phase 3.
  always_comb begin
    acc_d          = acc_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    if (valid_i) begin
      if (phase_i == 2'd0) begin
        acc_d = AW'(pixel_i);
      end else if (MODE == DS_MODE_AVG) begin
        acc_d = acc_q + AW'(pixel_i);
      end
      if (phase_i == 2'd3) begin
        result_valid_d = 1'b1;
        if (MODE == DS_MODE_AVG) begin
          result_d = BIT_DEPTH'((acc_d + AW'(2)) >> 2);
        end else begin
          result_d = acc_d[BIT_DEPTH-1:0];
        end
      end
    end
  end

  // Accumulator and result registers; the result holds between blocks.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      acc_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      acc_q          <= acc_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign result_o       = result_q;
  assign result_valid_o = result_valid_q;

endmodule

// File: rtl/downsample_img.sv
// Octave reduction: reads a WIDTH x HEIGHT image in 2x2 block-major order and
// writes a (WIDTH/2) x (HEIGHT/2) image, one output pixel every four cycles.
module downsample_img
  import sift_pkg::*;
#(
  parameter int BIT_DEPTH = 8,
  parameter int WIDTH     = 64,
  parameter int HEIGHT    = 64,
  parameter int MODE      = DS_MODE_AVG
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                start_in,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]     ext_read_addr,
  output logic                                ext_read_addr_valid,
  input  logic [BIT_DEPTH-1:0]                ext_pixel_in,
  output logic [$clog2(WIDTH*HEIGHT/4)-1:0]   ext_write_addr,
  output logic                                ext_write_valid,
  output logic [BIT_DEPTH-1:0]                ext_pixel_out,
  output logic                                busy_out,
  output logic                                done_out
);

  localparam int RAW     = $clog2(WIDTH*HEIGHT);
  localparam int WAW     = $clog2(WIDTH*HEIGHT/4);
  localparam int OXW     = (WIDTH  > 2) ? $clog2(WIDTH/2)  : 1;
  localparam int OYW     = (HEIGHT > 2) ? $clog2(HEIGHT/2) : 1;
  localparam int OX_LAST = WIDTH/2 - 1;
  localparam int OY_LAST = HEIGHT/2 - 1;
  localparam int N_OUT   = WIDTH*HEIGHT/4;
  localparam int unsigned LAT = BRAM_READ_LATENCY;

  ds_state_t      state_q, state_d;
  logic [OXW-1:0] ox_q, ox_d;
  logic [OYW-1:0] oy_q, oy_d;
  logic [1:0]     ph_q, ph_d;
  logic           last_read;

  logic [RAW-1:0] rd_addr;
  logic [WAW-1:0] blk_waddr;

  logic           tag_v_q  [LAT];
  logic [1:0]     tag_ph_q [LAT];
  logic [WAW-1:0] tag_wa_q [LAT];

  logic [WAW-1:0] wr_addr_q, wr_addr_d;
  logic           wr_valid;
  logic [BIT_DEPTH-1:0] wr_pixel;

  // Source address of the current phase and destination address of the current block.
  always_comb begin
    rd_addr   = RAW'((2*int'(ox_q) + int'(ph_q[0])) + (2*int'(oy_q) + int'(ph_q[1])) * WIDTH);
    blk_waddr = WAW'(int'(ox_q) + int'(oy_q) * (WIDTH/2));
  end

  // Sequencer: issue one read per cycle in block-major order, then wait for the final write.
  always_comb begin
    state_d   = state_q;
    ox_d      = ox_q;
    oy_d      = oy_q;
    ph_d      = ph_q;
    last_read = (ph_q == 2'd3) && (ox_q == OXW'(OX_LAST)) && (oy_q == OYW'(OY_LAST));
    case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d = ISSUE;
          ox_d    = '0;
          oy_d    = '0;
          ph_d    = '0;
        end
      end
      ISSUE: begin
        ph_d = ph_q + 2'd1;
        if (ph_q == 2'd3) begin
          if (ox_q == OXW'(OX_LAST)) begin
            ox_d = '0;
            oy_d = (oy_q == OYW'(OY_LAST)) ? '0 : oy_q + OYW'(1);
          end else begin
            ox_d = ox_q + OXW'(1);
          end
        end
        if (last_read) state_d = DRAIN;
      end
      DRAIN: begin
        if (wr_valid && (wr_addr_q == WAW'(N_OUT-1))) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM and read-position registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      ox_q    <= '0;
      oy_q    <= '0;
      ph_q    <= '0;
    end else begin
      state_q <= state_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      ph_q    <= ph_d;
    end
  end

  // Tag pipeline: phase and output address travel alongside each outstanding read.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        tag_v_q[i]  <= 1'b0;
        tag_ph_q[i] <= '0;
        tag_wa_q[i] <= '0;
      end
    end else begin
      tag_v_q[0]  <= ext_read_addr_valid;
      tag_ph_q[0] <= ph_q;
      tag_wa_q[0] <= blk_waddr;
      for (int unsigned i = 1; i < LAT; i++) begin
        tag_v_q[i]  <= tag_v_q[i-1];
        tag_ph_q[i] <= tag_ph_q[i-1];
        tag_wa_q[i] <= tag_wa_q[i-1];
      end
    end
  end

  // Capture the destination address in the same cycle the accumulator produces its result.
  always_comb begin
    wr_addr_d = wr_addr_q;
    if (tag_v_q[LAT-1] && (tag_ph_q[LAT-1] == 2'd3)) wr_addr_d = tag_wa_q[LAT-1];
  end

  // Registered write address.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) wr_addr_q <= '0;
    else         wr_addr_q <= wr_addr_d;
  end

  box2x2_accum #(
    .BIT_DEPTH (BIT_DEPTH),
    .MODE      (MODE)
  ) u_accum (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .pixel_i        (ext_pixel_in),
    .phase_i        (tag_ph_q[LAT-1]),
    .valid_i        (tag_v_q[LAT-1]),
    .result_o       (wr_pixel),
    .result_valid_o (wr_valid)
  );

  assign ext_read_addr       = rd_addr;
  assign ext_read_addr_valid = (state_q == ISSUE);
  assign ext_write_addr      = wr_addr_q;
  assign ext_write_valid     = wr_valid;
  assign ext_pixel_out       = wr_pixel;
  assign busy_out            = (state_q != IDLE);
  assign done_out            = (state_q == DONE);

endmodule

// File: tb/tb_downsample_img.sv
// Bench for downsample_img: three instances (4x4 average, 4x4 decimate, 64x64 average),
// each fed by a 2-cycle-latency BRAM model and checked against an arithmetic reference.
module tb_downsample_img;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [NI-1:0] start_a;
  logic [NI-1:0] rv_a, wv_a, busy_a, done_a;
  logic [7:0]    d1 [NI];
  logic [7:0]    d2 [NI];
  logic [7:0]    mem [NI][4096];

  logic [3:0]  ra0, ra1;
  logic [11:0] ra2;
  logic [1:0]  wa0, wa1;
  logic [9:0]  wa2;
  logic [7:0]  wd0, wd1, wd2;

  downsample_img #(.BIT_DEPTH(8), .WIDTH(4), .HEIGHT(4), .MODE(sift_pkg::DS_MODE_AVG)) dut0 (
    .clk_in(clk), .rst_in(rst_n), .start_in(start_a[0]),
    .ext_read_addr(ra0), .ext_read_addr_valid(rv_a[0]), .ext_pixel_in(d2[0]),
    .ext_write_addr(wa0), .ext_write_valid(wv_a[0]), .ext_pixel_out(wd0),
    .busy_out(busy_a[0]), .done_out(done_a[0]));

  downsample_img #(.BIT_DEPTH(8), .WIDTH(4), .HEIGHT(4), .MODE(sift_pkg::DS_MODE_DECIMATE)) dut1 (
    .clk_in(clk), .rst_in(rst_n), .start_in(start_a[1]),
    .ext_read_addr(ra1), .ext_read_addr_valid(rv_a[1]), .ext_pixel_in(d2[1]),
    .ext_write_addr(wa1), .ext_write_valid(wv_a[1]), .ext_pixel_out(wd1),
    .busy_out(busy_a[1]), .done_out(done_a[1]));

  downsample_img #(.BIT_DEPTH(8), .WIDTH(64), .HEIGHT(64), .MODE(sift_pkg::DS_MODE_AVG)) dut2 (
    .clk_in(clk), .rst_in(rst_n), .start_in(start_a[2]),
    .ext_read_addr(ra2), .ext_read_addr_valid(rv_a[2]), .ext_pixel_in(d2[2]),
    .ext_write_addr(wa2), .ext_write_valid(wv_a[2]), .ext_pixel_out(wd2),
    .busy_out(busy_a[2]), .done_out(done_a[2]));

  function automatic int ra(input int k);
    case (k)
      0:       return int'(ra0);
      1:       return int'(ra1);
      default: return int'(ra2);
    endcase
  endfunction

  function automatic int wa(input int k);
    case (k)
      0:       return int'(wa0);
      1:       return int'(wa1);
      default: return int'(wa2);
    endcase
  endfunction

  function automatic int wd(input int k);
    case (k)
      0:       return int'(wd0);
      1:       return int'(wd1);
      default: return int'(wd2);
    endcase
  endfunction

  function automatic int gw(input int k);
    return (k == 2) ? 64 : 4;
  endfunction

  // BRAM model: address sampled at an edge, data appears two edges later.
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      d1[k] <= mem[k][ra(k)];
      d2[k] <= d1[k];
    end
  end

  // Reference: address of the i-th read of a pass (block-major, 4 phases per block).
  function automatic int exp_rd_addr(input int k, input int i);
    int w, b, p, ox, oy;
    w  = gw(k);
    b  = i / 4;
    p  = i % 4;
    ox = b % (w/2);
    oy = b / (w/2);
    return (2*ox + (p % 2)) + (2*oy + p/2) * w;
  endfunction

  // Reference: output pixel for block b from the image held in the BRAM model.
  function automatic int model_px(input int k, input int b);
    int w, ox, oy, base, s;
    w    = gw(k);
    ox   = b % (w/2);
    oy   = b / (w/2);
    base = 2*ox + 2*oy*w;
    if (k == 1) return int'(mem[k][base]);
    s = int'(mem[k][base]) + int'(mem[k][base+1]) + int'(mem[k][base+w]) + int'(mem[k][base+w+1]);
    return (s + 2) / 4;
  endfunction

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  wr_t wrq [NI][$];
  int  t0 [NI];
  int  rd_cnt [NI], rd_first [NI], rd_last [NI], rd_bad [NI];
  int  done_cnt [NI], done_cyc [NI];
  int  busy_cnt [NI], busy_first [NI], busy_last [NI];
  int  edge_n = -1;
  int  nchk = 0;
  int  nerr = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Monitor: log reads, writes, done and busy with their cycle number within the pass.
  initial begin
    int c;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        c = edge_n - t0[k] + 1;
        if (rv_a[k]) begin
          if (ra(k) != exp_rd_addr(k, rd_cnt[k])) rd_bad[k]++;
          if (rd_cnt[k] == 0) rd_first[k] = c;
          rd_last[k] = c;
          rd_cnt[k]++;
        end
        if (wv_a[k]) wrq[k].push_back('{c, wa(k), wd(k)});
        if (done_a[k]) begin
          done_cnt[k]++;
          done_cyc[k] = c;
        end
        if (busy_a[k]) begin
          if (busy_cnt[k] == 0) busy_first[k] = c;
          busy_last[k] = c;
          busy_cnt[k]++;
        end
      end
    end
  end

  function automatic void check(input string name, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endfunction

  function automatic void clear_mon(input int k);
    wrq[k].delete();
    rd_cnt[k] = 0; rd_first[k] = 0; rd_last[k] = 0; rd_bad[k] = 0;
    done_cnt[k] = 0; done_cyc[k] = 0;
    busy_cnt[k] = 0; busy_first[k] = 0; busy_last[k] = 0;
  endfunction

  function automatic int wr_data(input int k, input int i);
    if (i < wrq[k].size()) return wrq[k][i].data;
    return -1;
  endfunction

  function automatic bit all_done(input logic [NI-1:0] mask);
    for (int k = 0; k < NI; k++)
      if (mask[k] && done_cnt[k] == 0) return 1'b0;
    return 1'b1;
  endfunction

  // Pulse start on the masked instances; returns at the negedge of cycle 1.
  task automatic start_pass(input logic [NI-1:0] mask);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      if (mask[k]) begin
        clear_mon(k);
        t0[k] = edge_n + 1;
      end
    end
    start_a = mask;
    @(negedge clk);
    start_a = '0;
  endtask

  task automatic wait_end(input logic [NI-1:0] mask, input int budget);
    int n;
    n = 0;
    while (n < budget && !all_done(mask)) begin
      @(negedge clk);
      n++;
    end
    check("pass_timeout", int'(n < budget), 1);
    repeat (8) @(negedge clk);
  endtask

  task automatic check_pass(input int k);
    int n, nout, bad_a, bad_d, bad_c;
    n = gw(k) * gw(k);
    nout = n / 4;
    bad_a = 0; bad_d = 0; bad_c = 0;
    check($sformatf("i%0d_write_count", k), wrq[k].size(), nout);
    for (int i = 0; i < wrq[k].size(); i++) begin
      if (wrq[k][i].addr != i) bad_a++;
      if (wrq[k][i].data != model_px(k, i)) bad_d++;
      if (wrq[k][i].cyc != 4*i + 7) bad_c++;
    end
    check($sformatf("i%0d_write_addr_errs", k), bad_a, 0);
    check($sformatf("i%0d_write_data_errs", k), bad_d, 0);
    check($sformatf("i%0d_write_cycle_errs", k), bad_c, 0);
    check($sformatf("i%0d_read_count", k), rd_cnt[k], n);
    check($sformatf("i%0d_read_first", k), rd_first[k], 1);
    check($sformatf("i%0d_read_last", k), rd_last[k], n);
    check($sformatf("i%0d_read_order_errs", k), rd_bad[k], 0);
    check($sformatf("i%0d_done_count", k), done_cnt[k], 1);
    check($sformatf("i%0d_done_cycle", k), done_cyc[k], n + 4);
    check($sformatf("i%0d_busy_count", k), busy_cnt[k], n + 4);
    check($sformatf("i%0d_busy_first", k), busy_first[k], 1);
    check($sformatf("i%0d_busy_last", k), busy_last[k], n + 4);
  endtask

  task automatic check_outputs_zero(input int k, input string tag);
    check({tag, "_rd_valid"}, int'(rv_a[k]), 0);
    check({tag, "_rd_addr"}, ra(k), 0);
    check({tag, "_wr_valid"}, int'(wv_a[k]), 0);
    check({tag, "_wr_addr"}, wa(k), 0);
    check({tag, "_pixel_out"}, wd(k), 0);
    check({tag, "_busy"}, int'(busy_a[k]), 0);
    check({tag, "_done"}, int'(done_a[k]), 0);
  endtask

  task automatic load_ramp();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++) mem[k][i] = 8'(i);
  endtask

  typedef struct {
    int p0, p1, p2, p3;
    int avg;
    int dec;
  } blk_vec_t;

  blk_vec_t tbl [8];
  int ramp_avg [4];
  int ramp_dec [4];

  initial begin
    tbl[0] = '{1, 1, 1, 0, 1, 1};
    tbl[1] = '{1, 1, 0, 0, 1, 1};
    tbl[2] = '{1, 0, 0, 0, 0, 1};
    tbl[3] = '{255, 255, 255, 255, 255, 255};
    tbl[4] = '{0, 0, 0, 0, 0, 0};
    tbl[5] = '{0, 0, 0, 2, 1, 0};
    tbl[6] = '{10, 20, 30, 41, 25, 10};
    tbl[7] = '{255, 255, 255, 254, 255, 255};
    ramp_avg = '{3, 5, 11, 13};
    ramp_dec = '{0, 2, 8, 10};

    rst_n   = 1'b0;
    start_a = '0;
    for (int k = 0; k < NI; k++) begin
      clear_mon(k);
      t0[k] = 0;
      for (int i = 0; i < 4096; i++) mem[k][i] = 8'd0;
    end
    #2;
    for (int k = 0; k < NI; k++) check_outputs_zero(k, $sformatf("i%0d_reset", k));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 4x4 ramp on both small instances: average and decimate.
    load_ramp();
    start_pass(3'b011);
    wait_end(3'b011, 200);
    check_pass(0);
    check_pass(1);
    for (int b = 0; b < 4; b++) begin
      check($sformatf("ramp_avg_b%0d", b), wr_data(0, b), ramp_avg[b]);
      check($sformatf("ramp_dec_b%0d", b), wr_data(1, b), ramp_dec[b]);
    end

    // Rounding / boundary blocks, four table rows per 4x4 image.
    for (int j = 0; j < 2; j++) begin
      for (int b = 0; b < 4; b++) begin
        int base;
        base = 2*(b % 2) + 8*(b / 2);
        for (int k = 0; k < 2; k++) begin
          mem[k][base]   = 8'(tbl[4*j+b].p0);
          mem[k][base+1] = 8'(tbl[4*j+b].p1);
          mem[k][base+4] = 8'(tbl[4*j+b].p2);
          mem[k][base+5] = 8'(tbl[4*j+b].p3);
        end
      end
      start_pass(3'b011);
      wait_end(3'b011, 200);
      for (int b = 0; b < 4; b++) begin
        check($sformatf("tbl%0d_avg", 4*j+b), wr_data(0, b), tbl[4*j+b].avg);
        check($sformatf("tbl%0d_dec", 4*j+b), wr_data(1, b), tbl[4*j+b].dec);
      end
    end

    // Random images: all three instances together, then extra small passes.
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < gw(k)*gw(k); i++) mem[k][i] = 8'($urandom_range(0, 255));
    start_pass(3'b111);
    wait_end(3'b111, 5000);
    for (int k = 0; k < NI; k++) check_pass(k);

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 16; i++) mem[k][i] = 8'($urandom_range(0, 255));
      start_pass(3'b011);
      wait_end(3'b011, 200);
      check_pass(0);
      check_pass(1);
    end

    // Asynchronous reset in cycle 8 of a pass, then a clean restart.
    load_ramp();
    start_pass(3'b011);
    repeat (7) @(negedge clk);
    check("rst_busy_before", int'(busy_a[0]), 1);
    check("rst_wvalid_before_seen", wrq[0].size(), 1);
    #1 rst_n = 1'b0;
    #1;
    check_outputs_zero(0, "i0_async_rst");
    check_outputs_zero(1, "i1_async_rst");
    repeat (2) @(negedge clk);
    clear_mon(0);
    clear_mon(1);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("i%0d_post_rst_writes", k), wrq[k].size(), 0);
      check($sformatf("i%0d_post_rst_reads", k), rd_cnt[k], 0);
      check($sformatf("i%0d_post_rst_busy", k), busy_cnt[k], 0);
    end
    start_pass(3'b011);
    wait_end(3'b011, 200);
    check_pass(0);
    check_pass(1);

    // start pulses at cycle 5 (mid-pass) and cycle 20 (with done_out) are ignored.
    load_ramp();
    start_pass(3'b011);
    repeat (4) @(negedge clk);
    start_a = 3'b011;
    @(negedge clk);
    start_a = '0;
    repeat (14) @(negedge clk);
    check("done_at_cycle20", int'(done_a[0]), 1);
    start_a = 3'b011;
    @(negedge clk);
    start_a = '0;
    wait_end(3'b011, 200);
    check_pass(0);
    check_pass(1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
